fmr_fault_monitor: RTL and testbench
====================================

# fmr_fault_monitor

Per-replica health monitor for the five-module-redundant datapath. It sits directly downstream of the 5-input majority voter and receives the same five replica bits plus the voted bit. It counts disagreements per replica in leaky saturating counters and raises sticky per-replica fault flags. It also reports when three or more replicas are faulty, at which point the voter output can no longer be trusted.

## Interface
Parameters:
- CNT_W, 4: width of each per-replica mismatch counter.
- FAULT_TH, 8: counter value at or above which a replica is declared faulty; legal range 1..2^CNT_W-1.
- LEAK_PERIOD, 16: number of valid samples per leak event; legal range ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  rep/voted carry a sample this cycle.
- rep  in  5  replica outputs a..e (bit 0 = a).
- voted  in  1  voter output z for the same sample.
- clr_faults  in  1  synchronous clear of counters, flags and leak timer.
- fault  out  5  sticky per-replica fault flags.
- n_faulty  out  3  popcount of fault.
- quorum_lost  out  1  n_faulty ≥ 3.
- err_pulse  out  1  one-cycle pulse: the last valid sample had at least one mismatch.
- voter_err  out  1  sticky voter self-check failure (see Configuration).

## Operation
- mism[i] = rep[i] ^ voted, evaluated only when valid_in=1.
- Leak timer: counts valid samples 0..LEAK_PERIOD-1 and wraps to 0. A leak event is a valid sample taken when the timer is at LEAK_PERIOD-1.
- Per-replica counter cnt[i] on a valid sample:
  - If mism[i]=1: increment, saturating at 2^CNT_W-1. A mismatch on a leak cycle still increments; it is not also decremented.
  - Else, if this is a leak event and cnt[i]>0: decrement by 1.
  - Else: hold.
- fault[i] is set when the next-state cnt[i] ≥ FAULT_TH. It stays set until clr_faults or reset, even if the counter later leaks down.
- n_faulty and quorum_lost are registered from the next-state fault vector, so they are coherent with fault every cycle.
- err_pulse = |mism on the valid sample, registered. It is 0 on cycles following valid_in=0.
- clr_faults=1 zeroes cnt, fault, n_faulty, quorum_lost, voter_err and the leak timer, and forces err_pulse=0. It takes priority over a simultaneous valid sample, and that sample is discarded.
- valid_in=0: all state holds and err_pulse=0.

## Timing
- Every output is registered. A valid sample at edge N is reflected in all outputs after edge N+1.
- Back-to-back valid samples are accepted every cycle. There is no backpressure.
- Reset values are all 0: fault=5'b0, n_faulty=0, quorum_lost=0, err_pulse=0, voter_err=0. All counters and the leak timer also reset to 0.
- Reset asserted mid-operation clears all state immediately, asynchronously. The first sample after deassertion is treated as leak-timer index 0.
- A single replica mismatching on every sample reaches FAULT_TH after FAULT_TH samples. The leak does not delay it, because mismatching samples never decrement.

## Configuration
- FMR_MON_SELFCHECK_EN defined:
  - The block recomputes the 5-input majority of rep internally on each valid sample.
  - If the recomputed majority ≠ voted, voter_err sets (sticky) one cycle later. It clears only on clr_faults or reset.
- FMR_MON_SELFCHECK_EN undefined:
  - No majority logic is built.
  - voter_err is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset check: after reset, apply 20 valid samples with rep=5'b11111, voted=1. Required: fault=0, n_faulty=0, err_pulse=0 throughout.
- Single-replica fault: defaults, rep=5'b11110, voted=1 on 8 consecutive valid cycles. Required: err_pulse=1 after each sample; fault=5'b00001 and n_faulty=1 after the 8th sample, not before.
- Leak and priority: with LEAK_PERIOD=16, bit 1 mismatches on 3 samples, then 13 clean samples complete the 16-sample period. Required: cnt[1]=2 after the leak sample, and fault[1] stays 0. Variant: a mismatch on the leak sample itself gives +1 with no decrement.
- Quorum loss: drive replicas c, d, e to mismatch 8 times each. Required: fault=5'b11100, n_faulty=3, quorum_lost=1. Then clr_faults together with valid_in=1 and a mismatch gives all outputs 0 on the next cycle.
- Saturation and gaps: 20 mismatches on replica e, interleaved with valid_in=0 gaps. Required: cnt[4]=15 (no wrap), gap cycles keep err_pulse=0, and the state holds across gaps.
- Self-check (macro defined): rep=5'b00111, voted=0. Required: voter_err=1 next cycle and stays 1. With the macro undefined, voter_err stays 0.

Source files
------------

// File: rtl/fmr_fault_monitor.sv
// fmr_fault_monitor
//
// Per-replica health monitor for the five-module-redundant datapath. It sits
// behind the 5-input majority voter and watches the five replica bits along
// with the voted bit. Each replica has a leaky saturating mismatch counter.
// When a counter reaches FAULT_TH, a sticky fault flag is raised for that
// replica. When three or more replicas are faulty, quorum_lost is asserted.
//
// Optional feature: define FMR_MON_SELFCHECK_EN to build an internal majority
// recompute. It sets the sticky voter_err flag whenever the incoming voted bit
// disagrees with the majority of rep. Without the macro, voter_err is
// constant 0 and no majority logic is built.
//
// Ports:
//    clk          system clock, rising edge
//    rst_n        asynchronous active-low reset
//    valid_in     rep/voted carry a sample this cycle
//    rep[4:0]     replica outputs a..e (bit 0 = a)
//    voted        voter output for the same sample
//    clr_faults   synchronous clear of counters, flags and leak timer
//    fault[4:0]   sticky per-replica fault flags
//    n_faulty     popcount of fault
//    quorum_lost  n_faulty >= 3
//    err_pulse    one-cycle pulse: last valid sample had a mismatch
//    voter_err    sticky voter self-check failure
module fmr_fault_monitor #(
   parameter int CNT_W       = 4,
   parameter int FAULT_TH    = 8,
   parameter int LEAK_PERIOD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       valid_in,
   input  logic [4:0] rep,
   input  logic       voted,
   input  logic       clr_faults,
   output logic [4:0] fault,
   output logic [2:0] n_faulty,
   output logic       quorum_lost,
   output logic       err_pulse,
   output logic       voter_err
);

   localparam int              TW        = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] TH        = CNT_W'(FAULT_TH);
   localparam logic [TW-1:0]    LEAK_LAST = TW'(LEAK_PERIOD - 1);

   logic [4:0][CNT_W-1:0] cnt;
   logic [4:0][CNT_W-1:0] cnt_next;
   logic [TW-1:0]         timer;
   logic [TW-1:0]         timer_next;
   logic [4:0]            mism;
   logic [4:0]            fault_next;
   logic [2:0]            n_faulty_next;
   logic                  leak;
   logic                  voter_err_next;

   function automatic logic [2:0] popcount5(input logic [4:0] v);
      logic [2:0] s;
      s = '0;
      for (int i = 0; i < 5; i++) begin
         s = s + {2'b00, v[i]};
      end
      return s;
   endfunction

   // Next state assuming the current cycle carries a valid sample. The
   // register block only commits it when valid_in is high and no clear is
   // pending. A mismatching replica always counts up, even on a leak cycle,
   // so a persistently bad replica is never slowed down by the leak.
   always_comb begin
      mism       = rep ^ {5{voted}};
      leak       = (timer == LEAK_LAST);
      timer_next = leak ? '0 : timer + 1'b1;
      cnt_next   = cnt;
      fault_next = fault;
      for (int i = 0; i < 5; i++) begin
         if (mism[i]) begin
            if (cnt[i] != CNT_MAX) begin
               cnt_next[i] = cnt[i] + 1'b1;
            end
         end else if (leak && (cnt[i] != '0)) begin
            cnt_next[i] = cnt[i] - 1'b1;
         end
         fault_next[i] = fault[i] | (cnt_next[i] >= TH);
      end
      n_faulty_next = popcount5(fault_next);
   end

`ifdef FMR_MON_SELFCHECK_EN
   // Independent majority recompute, used to catch a broken upstream voter.
   always_comb begin
      voter_err_next = voter_err | ((popcount5(rep) >= 3'd3) != voted);
   end
`else
   always_comb begin
      voter_err_next = 1'b0;
   end
`endif

   // All outputs are registered from the same next-state vectors, so
   // fault, n_faulty and quorum_lost always agree. A clear wins over a
   // simultaneous sample, and that sample is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         timer       <= '0;
         fault       <= '0;
         n_faulty    <= '0;
         quorum_lost <= 1'b0;
         err_pulse   <= 1'b0;
         voter_err   <= 1'b0;
      end else if (clr_faults) begin
         cnt         <= '0;
         timer       <= '0;
         fault       <= '0;
         n_faulty    <= '0;
         quorum_lost <= 1'b0;
         err_pulse   <= 1'b0;
         voter_err   <= 1'b0;
      end else if (valid_in) begin
         cnt         <= cnt_next;
         timer       <= timer_next;
         fault       <= fault_next;
         n_faulty    <= n_faulty_next;
         quorum_lost <= (n_faulty_next >= 3'd3);
         err_pulse   <= |mism;
         voter_err   <= voter_err_next;
      end else begin
         err_pulse   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fmr_fault_monitor.sv
// tb_fmr_fault_monitor
//
// Testbench for fmr_fault_monitor using the default parameters
// (CNT_W=4, FAULT_TH=8, LEAK_PERIOD=16). Inputs are driven on the falling
// edge. The expected outputs for each sample are pushed into a scoreboard
// queue, and they are popped and compared on the next falling edge, after
// the DUT has registered the sample. The expected voter_err depends on
// whether FMR_MON_SELFCHECK_EN is defined.
module tb_fmr_fault_monitor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid_in = 1'b0;
   logic [4:0] rep = 5'b0;
   logic       voted = 1'b0;
   logic       clr_faults = 1'b0;
   logic [4:0] fault;
   logic [2:0] n_faulty;
   logic       quorum_lost;
   logic       err_pulse;
   logic       voter_err;

`ifdef FMR_MON_SELFCHECK_EN
   localparam bit SelfCheck = 1'b1;
`else
   localparam bit SelfCheck = 1'b0;
`endif

   typedef struct packed {
      logic [4:0] fault;
      logic [2:0] nFaulty;
      logic       quorumLost;
      logic       errPulse;
      logic       voterErr;
   } exp_t;

   typedef struct {
      logic       valid;
      logic [4:0] rep;
      logic       voted;
      logic       clr;
      logic [4:0] expFault;
      logic       expErr;
   } vec_t;

   exp_t expQ[$];
   vec_t vecs[12];
   int   nVectors = 0;
   int   nMiscompares = 0;
   logic expVerr = 1'b0;

   fmr_fault_monitor dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_in    (valid_in),
      .rep         (rep),
      .voted       (voted),
      .clr_faults  (clr_faults),
      .fault       (fault),
      .n_faulty    (n_faulty),
      .quorum_lost (quorum_lost),
      .err_pulse   (err_pulse),
      .voter_err   (voter_err)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Stop a runaway run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic maj5(input logic [4:0] v);
      return ($countones(v) >= 3);
   endfunction

   // Drive one cycle of inputs and push the expected outputs for that
   // cycle. Returns on the next falling edge, after the DUT has registered
   // the sample.
   task automatic applyStimulus(input logic v, input logic [4:0] r, input logic z,
                                input logic c, input logic [4:0] eFault, input logic eErr);
      exp_t e;
      valid_in   = v;
      rep        = r;
      voted      = z;
      clr_faults = c;
      if (c) begin
         expVerr = 1'b0;
      end else if (v && SelfCheck && (maj5(r) != z)) begin
         expVerr = 1'b1;
      end
      e.fault      = eFault;
      e.nFaulty    = 3'($countones(eFault));
      e.quorumLost = ($countones(eFault) >= 3);
      e.errPulse   = eErr;
      e.voterErr   = expVerr;
      expQ.push_back(e);
      @(negedge clk);
   endtask

   // Pop the oldest expectation and compare it with the registered outputs.
   task automatic checkOutput(input string name);
      exp_t e;
      nVectors++;
      if (expQ.size() == 0) begin
         nMiscompares++;
         $display("[TB] FAIL %s: scoreboard empty, no expectation to compare", name);
         return;
      end
      e = expQ.pop_front();
      if ({fault, n_faulty, quorum_lost, err_pulse, voter_err} !== e) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got fault=%b n_faulty=%0d quorum_lost=%b err_pulse=%b voter_err=%b, expected fault=%b n_faulty=%0d quorum_lost=%b err_pulse=%b voter_err=%b",
                  name, fault, n_faulty, quorum_lost, err_pulse, voter_err,
                  e.fault, e.nFaulty, e.quorumLost, e.errPulse, e.voterErr);
      end
   endtask

   task automatic step(input logic v, input logic [4:0] r, input logic z, input logic c,
                       input logic [4:0] eFault, input logic eErr, input string name);
      applyStimulus(v, r, z, c, eFault, eErr);
      checkOutput(name);
   endtask

   task automatic checkValue(input string name, input int actual, input int expected);
      nVectors++;
      if (actual != expected) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   initial begin
      // Single-replica fault table. Row 0 is a clear that discards its sample,
      // and the last row clears again.
      vecs[0] = '{1'b1, 5'b11110, 1'b1, 1'b1, 5'b00000, 1'b0};
      for (int k = 1; k <= 8; k++) begin
         vecs[k] = '{1'b1, 5'b11110, 1'b1, 1'b0, (k == 8) ? 5'b00001 : 5'b00000, 1'b1};
      end
      vecs[9]  = '{1'b0, 5'b11110, 1'b1, 1'b0, 5'b00001, 1'b0};
      vecs[10] = '{1'b1, 5'b00000, 1'b0, 1'b0, 5'b00001, 1'b0};
      vecs[11] = '{1'b1, 5'b11111, 1'b1, 1'b1, 5'b00000, 1'b0};

      repeat (2) @(negedge clk);
      checkValue("reset_outputs", int'({fault, n_faulty, quorum_lost, err_pulse, voter_err}), 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] reset check: 20 clean samples");
      for (int k = 0; k < 20; k++) begin
         step(1'b1, 5'b11111, 1'b1, 1'b0, 5'b00000, 1'b0, "clean_after_reset");
      end

      $display("[TB] single-replica fault table");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].rep, vecs[i].voted, vecs[i].clr,
                       vecs[i].expFault, vecs[i].expErr);
         checkOutput($sformatf("table_row%0d", i));
      end

      $display("[TB] leak: 3 mismatches on b, then 13 clean samples");
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 5'b11101, 1'b1, 1'b0, 5'b00000, 1'b1, "leak_mism");
      end
      for (int k = 0; k < 13; k++) begin
         step(1'b1, 5'b11111, 1'b1, 1'b0, 5'b00000, 1'b0, "leak_clean");
      end
      checkValue("leak_cnt1_after_leak", int'(dut.cnt[1]), 2);
      for (int k = 0; k < 15; k++) begin
         step(1'b1, 5'b11111, 1'b1, 1'b0, 5'b00000, 1'b0, "leak_clean2");
      end
      step(1'b1, 5'b11101, 1'b1, 1'b0, 5'b00000, 1'b1, "mism_on_leak");
      checkValue("mism_on_leak_cnt1", int'(dut.cnt[1]), 3);
      for (int k = 1; k <= 5; k++) begin
         step(1'b1, 5'b11101, 1'b1, 1'b0, (k == 5) ? 5'b00010 : 5'b00000, 1'b1, "b_to_fault");
      end
      step(1'b1, 5'b11111, 1'b1, 1'b1, 5'b00000, 1'b0, "clear_after_leak");

      $display("[TB] quorum loss on c, d, e");
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 5'b00011, 1'b1, 1'b0, (k == 8) ? 5'b11100 : 5'b00000, 1'b1, "quorum");
      end
      step(1'b1, 5'b00000, 1'b1, 1'b1, 5'b00000, 1'b0, "clear_beats_sample");

      $display("[TB] saturation on e with gaps");
      for (int k = 1; k <= 20; k++) begin
         step(1'b1, 5'b01111, 1'b1, 1'b0, (k >= 8) ? 5'b10000 : 5'b00000, 1'b1, "sat_mism");
         step(1'b0, 5'b01111, 1'b1, 1'b0, (k >= 8) ? 5'b10000 : 5'b00000, 1'b0, "sat_gap");
      end
      checkValue("sat_cnt4", int'(dut.cnt[4]), 15);

      $display("[TB] asynchronous reset mid-operation");
      #2;
      rst_n = 1'b0;
      #1;
      checkValue("async_reset_outputs", int'({fault, n_faulty, quorum_lost, err_pulse, voter_err}), 0);
      checkValue("async_reset_cnt4", int'(dut.cnt[4]), 0);
      expVerr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] voter self-check, then the first leak after reset");
      step(1'b1, 5'b00111, 1'b0, 1'b0, 5'b00000, 1'b1, "selfcheck_bad_vote");
      for (int k = 0; k < 14; k++) begin
         step(1'b1, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, "selfcheck_hold");
      end
      checkValue("pre_leak_cnt0", int'(dut.cnt[0]), 1);
      step(1'b1, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, "first_leak_after_reset");
      checkValue("post_leak_cnt0", int'(dut.cnt[0]), 0);
      step(1'b0, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, "selfcheck_gap");

      $display("[TB] == %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
